// File: rtl/piso_tx_if.sv
// Purpose      : word handshake and serial-output bundle for the piso_tx transmitter.
// Latency      : n/a (signal bundle only).
// Backpressure : producer holds load until it sees ready; serial side has none.
//
// Signals:
//   din       [WIDTH-1:0]  parallel word from the producer
//   load                   word-valid strobe from the producer
//   ready                  transmitter accepts a word this cycle
//   out                    serial data bit
//   out_valid              out carries a frame bit this cycle
//   busy                   a frame is in progress
//   done                   one-cycle pulse on the final bit of a frame
// Modports: master = producer / serial consumer side, slave = transmitter.
interface piso_tx_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] din;
    logic             load;
    logic             ready;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output din,
        output load,
        input  ready,
        input  out,
        input  out_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  din,
        input  load,
        output ready,
        output out,
        output out_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_tx.sv
// Purpose      : parallel-in serial-out transmitter, one bit per clk, zero-gap word chaining.
// Latency      : first bit one cycle after acceptance; frame WIDTH cycles (WIDTH+1 with parity).
// Backpressure : ready only when idle or on the final frame bit; load at other times is ignored.
//
// Ports:
//   clk    rising-edge clock
//   clear  synchronous active-high reset; also forces ready low combinationally
//   bus    piso_tx_if.slave: din/load/ready handshake, out/out_valid/busy/done serial side
// Parameters:
//   WIDTH      word width (>= 2)
//   LSB_FIRST  0 = MSB transmitted first, 1 = LSB transmitted first
// Build option:
//   PISO_TX_PARITY_EN  when defined, each frame ends with one even-parity bit (PAR state).
module piso_tx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       clear,
    piso_tx_if.slave   bus
);

    localparam int              CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef PISO_TX_PARITY_EN
    logic             par_q, par_d;
`endif

    logic             frame_end;   // cycle that carries done and reopens ready
    logic             accept;
    logic             sr_out_bit;
    logic [WIDTH-1:0] sr_shifted;

    // ------------------------------------------------------------------
    // Decode from registered state only
    // ------------------------------------------------------------------
`ifdef PISO_TX_PARITY_EN
    assign frame_end = (state_q == PAR);
`else
    assign frame_end = (state_q == SHIFT) && (cnt_q == '0);
`endif

    // Ready never looks at load/din, so the producer sees no combinational loop.
    assign bus.ready = !clear && ((state_q == IDLE) || frame_end);
    assign accept    = bus.load && bus.ready;

    // The output end of sr is fixed by bit order; shifting always moves bits
    // toward that end and zero-fills the opposite end.
    assign sr_out_bit = LSB_FIRST ? sr_q[0] : sr_q[WIDTH-1];
    assign sr_shifted = LSB_FIRST ? {1'b0, sr_q[WIDTH-1:1]}
                                  : {sr_q[WIDTH-2:0], 1'b0};

    always_comb begin
        bus.out = 1'b0;
        case (state_q)
            SHIFT:   bus.out = sr_out_bit;
`ifdef PISO_TX_PARITY_EN
            PAR:     bus.out = par_q;
`endif
            default: bus.out = 1'b0;
        endcase
    end

    assign bus.out_valid = (state_q != IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = frame_end;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
`ifdef PISO_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    sr_d    = bus.din;
                    cnt_d   = CNT_LAST;
`ifdef PISO_TX_PARITY_EN
                    par_d   = ^bus.din;
`endif
                end
            end

            SHIFT: begin
                sr_d = sr_shifted;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
`ifdef PISO_TX_PARITY_EN
                    // Last data bit: parity bit follows, ready stays low.
                    state_d = PAR;
`else
                    // Last data bit: chain the next word with no idle gap.
                    if (accept) begin
                        sr_d  = bus.din;
                        cnt_d = CNT_LAST;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end

`ifdef PISO_TX_PARITY_EN
            PAR: begin
                if (accept) begin
                    state_d = SHIFT;
                    sr_d    = bus.din;
                    cnt_d   = CNT_LAST;
                    par_d   = ^bus.din;
                end else begin
                    state_d = IDLE;
                end
            end
`endif

            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
`ifdef PISO_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
`ifdef PISO_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

endmodule

// File: doc/piso_tx.md
# piso_tx

Parallel-in, serial-out transmitter: the driving end of the serial shift-register link in the `Sequential/register` family. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out one bit per clock on a single serial line. It marks each transmitted bit with a qualifier and pulses `done` on the final bit. It supports back-to-back words with no idle gap, so a serial receiver (SISO/SIPO) can sit directly downstream.

## Interface
- `WIDTH`, default 8: data word width; legal range ≥ 2.
- `LSB_FIRST`, default 0: 0 transmits MSB first; 1 transmits LSB first.

- `clk`  in  1: single clock; all logic on the rising edge.
- `clear`  in  1: reset, synchronous and active-high.
- `din`  in  WIDTH: parallel word, sampled when `load && ready`.
- `load`  in  1: word-valid strobe from the producer.
- `ready`  out  1: transmitter can accept a word this cycle.
- `out`  out  1: serial data bit.
- `out_valid`  out  1: `out` carries a frame bit this cycle.
- `busy`  out  1: a frame is in progress.
- `done`  out  1: one-cycle pulse coinciding with the final bit of a frame.

## Operation
- Internal state:
  - shift register `sr[WIDTH-1:0]`;
  - bit counter, width `$clog2(WIDTH)`;
  - FSM with states IDLE, SHIFT and (with parity) PAR.
- **Reset.** Synchronous reset while `clear` is high forces:
  - state IDLE, `sr`=0, counter=0;
  - `out`=0, `out_valid`=0, `busy`=0, `done`=0.
  - `ready` is forced to 0 combinationally while `clear`=1.
- **IDLE.**
  - `ready`=1, `out`=0, `out_valid`=0.
  - On `load && ready`: capture `din` into `sr`, counter ← WIDTH-1, go to SHIFT.
- **SHIFT.**
  - `out` = `sr[WIDTH-1]` (MSB-first) or `sr[0]` (LSB-first); `out_valid`=1; `busy`=1.
  - Each clock, shift `sr` toward the output end, zero-filling, and decrement the counter.
- **Last data bit** (counter = 0):
  - Without parity: `done`=1 and `ready`=1 this cycle.
  - On the edge ending this cycle:
    - if `load`=1: reload `sr` from `din`, counter ← WIDTH-1, stay in SHIFT (zero-gap chaining);
    - else: go to IDLE.
  - With parity: go to PAR instead; `ready` and `done` stay 0 during the last data bit.
- **Mid-frame loads.** `load` during SHIFT while `ready`=0 is ignored; no capture and no side effect.
- **Source data.** `din` is don't-care except in the cycle of acceptance.
- **Clear mid-frame.** The frame is aborted with no `done`. The next cycle shows reset values.
- **Simultaneous `clear` and `load`.** `clear` wins; the word is dropped.

## Timing
- Accept at edge k. Data bits appear in the cycles after edges k … k+WIDTH-1, so the first bit is visible one cycle after acceptance.
- Frame length:
  - WIDTH cycles without parity;
  - WIDTH+1 cycles with parity.
- `done` is high exactly one cycle, aligned with the final frame bit.
- Throughput:
  - without parity, one word per WIDTH cycles sustained;
  - with parity, one word per WIDTH+1 cycles sustained.
- Output registering:
  - `out`, `out_valid`, `busy` and `done` are decoded from registered state and `sr` only; they have no combinational path from `din` or `load`.
  - `ready` depends only on state, counter and `clear`.

## Configuration
- Macro: `PISO_TX_PARITY_EN`.
- **When defined:**
  - After the last data bit, the FSM enters PAR for one cycle.
  - In PAR, `out` = even parity, i.e. the XOR of all WIDTH bits of the accepted word, computed at capture and held in a register; `out_valid`=1.
  - PAR carries `done`=1 and `ready`=1, with the same chaining rule as the last data bit.
- **When undefined:** there is no PAR state and no parity register. The frame is exactly WIDTH bits.

## Test plan
- **Reset:** hold `clear`=1 for 3 cycles with `load`=1 → `ready`=0, `out`=0, `out_valid`=0, `busy`=0, `done`=0. After release, `ready`=1 the next cycle.
- **Single frame:** WIDTH=8, MSB-first, `din`=8'hA5 accepted at edge k → `out` = 1,0,1,0,0,1,0,1 in cycles k+1 … k+8, with `out_valid`=1 throughout. `done`=1 only at k+8, then IDLE with `out`=0.
- **Back-to-back:** load 8'hA5, then 8'h3C asserted during the final-bit cycle → 16 consecutive valid bits 10100101 00111100 with no gap, and two `done` pulses 8 cycles apart.
- **Bit order / ignored load:** `LSB_FIRST`=1, `din`=8'h01 → `out` = 1 then seven 0s. Pulsing `load` with 8'hFF at bit 3 changes nothing.
- **Abort:** `clear`=1 at bit 3 of 8'hFF → the next cycle shows `out`=0, `out_valid`=0, `busy`=0, and no `done` pulse. A new load afterwards transmits correctly.
- **Parity** (`PISO_TX_PARITY_EN` defined):
  - `din`=8'h07 → 9-bit frame ending with parity bit 1, with `done` on the 9th bit.
  - `din`=8'h03 → parity bit 0.
